// File: rtl/rv_muldiv_iter.sv
// Iterative RV32M/RV64M multiply/divide unit.
// Radix-2 shift-add multiply and restoring divide, one bit per clock, on
// operand magnitudes; the result sign is applied on the final iteration.
module rv_muldiv_iter #(
    parameter int unsigned XLEN         = 32,
    parameter bit          FAST_SPECIAL = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [4:0]      in_tag,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_tag,
    output logic            busy
);

    localparam int unsigned CW = $clog2(XLEN);
    localparam int unsigned PW = 2 * XLEN;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    logic [2:0]      op_q;
    logic [4:0]      tag_q;
    logic            neg_q;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] mcand;

    // Request decode: operand signedness, magnitudes, result sign and special cases
    logic            a_signed;
    logic            b_signed;
    logic            sign_a;
    logic            sign_b;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            b_zero;
    logic            ovf;
    logic            special;
    logic [XLEN-1:0] spec_res;
    logic            acc_neg;

    always_comb begin
        a_signed = in_op[2] ? ~in_op[0] : (in_op[1:0] != 2'b11);
        b_signed = in_op[2] ? ~in_op[0] : ~in_op[1];
        sign_a   = a_signed & in_a[XLEN-1];
        sign_b   = b_signed & in_b[XLEN-1];
        mag_a    = sign_a ? -in_a : in_a;
        mag_b    = sign_b ? -in_b : in_b;
        b_zero   = (in_b == '0);
        ovf      = in_op[2] & ~in_op[0]
                 & (in_a == {1'b1, {(XLEN-1){1'b0}}})
                 & (in_b == '1);
        special  = in_op[2] & (b_zero | ovf);
        if (b_zero) begin
            spec_res = in_op[1] ? in_a : '1;
        end else begin
            spec_res = in_op[1] ? '0 : in_a;
        end
        // Quotient sign is dropped on divide-by-zero so the iterative path
        // yields all ones, matching the bypass result.
        if (!in_op[2]) begin
            acc_neg = sign_a ^ sign_b;
        end else if (in_op[1]) begin
            acc_neg = sign_a;
        end else begin
            acc_neg = (sign_a ^ sign_b) & ~b_zero;
        end
    end

    // One iteration step: shift-add for multiply, restoring subtract for divide
    logic [XLEN:0]   sum;
    logic [XLEN:0]   rshift;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] hi_n;
    logic [XLEN-1:0] lo_n;

    always_comb begin
        sum    = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
        rshift = {hi, lo[XLEN-1]};
        diff   = rshift - {1'b0, mcand};
        if (!op_q[2]) begin
            hi_n = sum[XLEN:1];
            lo_n = {sum[0], lo[XLEN-1:1]};
        end else if (!diff[XLEN]) begin
            hi_n = diff[XLEN-1:0];
            lo_n = {lo[XLEN-2:0], 1'b1};
        end else begin
            hi_n = rshift[XLEN-1:0];
            lo_n = {lo[XLEN-2:0], 1'b0};
        end
    end

    // Final result formed from the last iteration's outputs
    logic [PW-1:0]   prod;
    logic [PW-1:0]   prod_s;
    logic [XLEN-1:0] div_sel;
    logic [XLEN-1:0] res;

    always_comb begin
        prod    = {hi_n, lo_n};
        prod_s  = neg_q ? -prod : prod;
        div_sel = op_q[1] ? hi_n : lo_n;
        if (!op_q[2]) begin
            res = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[PW-1:XLEN];
        end else begin
            res = neg_q ? -div_sel : div_sel;
        end
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            op_q       <= '0;
            tag_q      <= '0;
            neg_q      <= 1'b0;
            count      <= '0;
            hi         <= '0;
            lo         <= '0;
            mcand      <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
            busy       <= 1'b0;
        end else if (flush) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q     <= in_op;
                        tag_q    <= in_tag;
                        neg_q    <= acc_neg;
                        hi       <= '0;
                        lo       <= in_op[2] ? mag_a : mag_b;
                        mcand    <= in_op[2] ? mag_b : mag_a;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (FAST_SPECIAL && special) begin
                            state      <= S_DONE;
                            count      <= '0;
                            out_valid  <= 1'b1;
                            out_result <= spec_res;
                            out_tag    <= in_tag;
                        end else begin
                            state <= S_BUSY;
                            count <= CW'(XLEN - 1);
                        end
                    end
                end
                S_BUSY: begin
                    hi    <= hi_n;
                    lo    <= lo_n;
                    count <= count - CW'(1);
                    if (count == '0) begin
                        state      <= S_DONE;
                        out_valid  <= 1'b1;
                        out_result <= res;
                        out_tag    <= tag_q;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
